seg_scroll_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver and successor to the fixed four-digit driver.
- Supports NUM_DIGITS digits, all seven segments (a..g) and a decimal point.
- Holds a writable message buffer of hex/blank characters and can scroll the message across the display.
- Sits between board-level anodes/segments and any control logic that writes characters.

---
 rtl/seg_pkg.sv | 9 +
 rtl/seg_scroll_driver_hex_to_seg.sv | 14 +
 rtl/seg_scroll_driver.sv | 92 +++++++++
 tb/tb_seg_scroll_driver.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: character type, blank code and active-high hex glyph table shared by the display driver
package seg_pkg;
  typedef logic [4:0] char_t;
  localparam char_t BLANK = 5'h10;
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/seg_scroll_driver_hex_to_seg.sv
// hex_to_seg: combinational character to active-high {g..a} segments and decimal point
module hex_to_seg
  import seg_pkg::*;
(
  input  char_t      ch,
  input  logic       dp_in,
  output logic [6:0] seg,
  output logic       dp
);
  always_comb begin
    seg = ch[4] ? 7'h00 : GLYPHS[ch[3:0]];
    dp  = dp_in & ~ch[4];
  end
endmodule

// File: rtl/seg_scroll_driver.sv
// seg_scroll_driver: multiplexed seven-segment driver with a writable, scrollable message buffer
module seg_scroll_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int MSG_DEPTH        = 16,
  parameter int SCROLL_DIV       = 100,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [4:0]                   wr_char,
  input  logic                         wr_dp,
  input  logic [$clog2(MSG_DEPTH):0]   msg_len,
  input  logic                         scroll_en,
  output logic [NUM_DIGITS-1:0]        an,
  output logic [6:0]                   seg,
  output logic                         dp,
  output logic                         frame_tick
);
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1;
  localparam int PW = AW + 5;
  localparam logic AL = ANODE_ACTIVE_LOW != 0;
  localparam logic SL = SEG_ACTIVE_LOW != 0;
  logic [DW-1:0]         div_cnt;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         frame_cnt;
  logic [AW-1:0]         offset;
  char_t                 mem_ch [MSG_DEPTH];
  logic                  mem_dp [MSG_DEPTH];
  logic [LW-1:0]         len;
  logic [PW-1:0]         pos;
  logic [AW-1:0]         rd_addr;
  logic                  tick;
  logic                  step;
  logic [NUM_DIGITS-1:0] an_hi;
  logic [6:0]            seg_hi;
  logic                  dp_hi;
  always_comb begin
    tick       = div_cnt == DW'(REFRESH_DIV - 1);
    frame_tick = tick && idx == IW'(NUM_DIGITS - 1);
    len        = msg_len == '0 ? LW'(1) : msg_len > LW'(MSG_DEPTH) ? LW'(MSG_DEPTH) : msg_len;
    step       = frame_tick && scroll_en && frame_cnt == FW'(SCROLL_DIV - 1);
    // digit idx counts from the right, so the leftmost digit reads entry offset
    pos        = PW'(offset) + PW'(NUM_DIGITS - 1) - PW'(idx);
    rd_addr    = AW'(pos % PW'(len));
    an_hi      = NUM_DIGITS'(1) << idx;
  end
  hex_to_seg u_dec (
    .ch   (mem_ch[rd_addr]),
    .dp_in(mem_dp[rd_addr]),
    .seg  (seg_hi),
    .dp   (dp_hi)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      offset    <= '0;
      an        <= {NUM_DIGITS{AL}};
      seg       <= {7{SL}};
      dp        <= SL;
      for (int i = 0; i < MSG_DEPTH; i++) begin
        mem_ch[i] <= BLANK;
        mem_dp[i] <= 1'b0;
      end
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      if (frame_tick && scroll_en) frame_cnt <= step ? '0 : frame_cnt + 1'b1;
      // a shrunk length takes priority over a pending scroll step
      if (LW'(offset) >= len) offset <= '0;
      else if (step) offset <= LW'(offset) + LW'(1) == len ? '0 : offset + 1'b1;
      if (wr_en) begin
        mem_ch[wr_addr] <= wr_char;
        mem_dp[wr_addr] <= wr_dp;
      end
      an  <= an_hi ^ {NUM_DIGITS{AL}};
      seg <= seg_hi ^ {7{SL}};
      dp  <= dp_hi ^ SL;
    end
  end
endmodule

// File: tb/tb_seg_scroll_driver.sv
// tb_seg_scroll_driver: directed scoreboard bench for the scrolling seven-segment driver
module tb_seg_scroll_driver;
  logic       clk = 0, rst = 1, wr_en = 0, wr_dp = 0, scroll_en = 0;
  logic [2:0] wr_addr = 0;
  logic [4:0] wr_char = 0;
  logic [3:0] msg_len = 4;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_tick;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct packed {logic [3:0] an; logic [6:0] seg; logic dp;} exp_t;
  exp_t q[$];
  logic [4:0] mch [8];
  logic       mdp [8];

  seg_scroll_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .MSG_DEPTH(8), .SCROLL_DIV(2),
    .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .wr_dp(wr_dp), .msg_len(msg_len), .scroll_en(scroll_en),
    .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      mch[i] = 5'h10;
      mdp[i] = 1'b0;
    end
  endtask

  task automatic wr(input int a, input logic [4:0] c, input logic d);
    wr_en = 1; wr_addr = 3'(a); wr_char = c; wr_dp = d;
    @(negedge clk);
    wr_en = 0;
    mch[a] = c;
    mdp[a] = d;
  endtask

  task automatic check_frame(input int off, input int len, input string tag);
    int l, a, n;
    exp_t e;
    l = len == 0 ? 1 : (len > 8 ? 8 : len);
    for (int k = 0; k < 4; k++) begin
      a = (off + 3 - k) % l;
      e.an  = ~(4'b0001 << k);
      e.seg = mch[a][4] ? 7'h7F : ~glyph(mch[a][3:0]);
      e.dp  = ~(mdp[a] & ~mch[a][4]);
      q.push_back(e);
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      n = 0;
      while (an !== e.an && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk({tag, " an"}, 32'(an), 32'(e.an));
      chk({tag, " seg"}, 32'(seg), 32'(e.seg));
      chk({tag, " dp"}, 32'(dp), 32'(e.dp));
    end
  endtask

  task automatic wait_off(input int want, input int bound, output int t);
    int n = 0;
    while (dut.offset !== 3'(want) && n < bound) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    chk("offset", 32'(dut.offset), 32'(want));
  endtask

  initial begin
    int t0, t1, n, tp;
    int seq[5] = '{1, 2, 3, 4, 0};
    clear_model();
    repeat (3) @(negedge clk);
    chk("reset an", 32'(an), 32'hF);
    chk("reset seg", 32'(seg), 32'h7F);
    chk("reset dp", 32'(dp), 32'h1);
    chk("reset frame_tick", 32'(frame_tick), 32'h0);
    rst = 0;
    @(negedge clk);
    chk("first digit an", 32'(an), 32'hE);
    wr(0, 5'h01, 0); wr(1, 5'h02, 0); wr(2, 5'h03, 0); wr(3, 5'h08, 0);
    @(negedge clk);
    check_frame(0, 4, "static");
    n = 0;
    while (an === 4'hE && n < 20) begin @(negedge clk); n++; end
    while (an !== 4'hE && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (an === 4'hE && n < 20) begin @(negedge clk); n++; end
    chk("digit hold cycles", 32'(n), 32'd4);
    n = 0;
    while (frame_tick !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    t0 = cyc;
    @(negedge clk);
    n = 0;
    while (frame_tick !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    t1 = cyc;
    chk("frame_tick spacing", 32'(t1 - t0), 32'd16);
    wr(0, 5'h10, 1); wr(3, 5'h0F, 1);
    @(negedge clk);
    check_frame(0, 4, "blank dp");
    wr(4, 5'h05, 0);
    msg_len = 5;
    scroll_en = 1;
    tp = 0;
    for (int i = 0; i < 5; i++) begin
      wait_off(seq[i], 40, t1);
      if (i > 0) chk("scroll spacing", 32'(t1 - tp), 32'd32);
      tp = t1;
      if (seq[i] == 3) check_frame(3, 5, "scroll off3");
    end
    wait_off(4, 140, t1);
    msg_len = 3;
    @(negedge clk);
    chk("shrink offset", 32'(dut.offset), 32'd0);
    wait_off(2, 80, t1);
    scroll_en = 0;
    repeat (160) @(negedge clk);
    chk("frozen offset", 32'(dut.offset), 32'd2);
    check_frame(2, 3, "frozen");
    n = 0;
    while (an !== 4'hB && n < 20) begin @(negedge clk); n++; end
    chk("digit2 lit", 32'(an), 32'hB);
    rst = 1;
    @(negedge clk);
    chk("midscan rst an", 32'(an), 32'hF);
    chk("midscan rst seg", 32'(seg), 32'h7F);
    chk("midscan rst dp", 32'(dp), 32'h1);
    chk("midscan rst frame_tick", 32'(frame_tick), 32'h0);
    chk("midscan rst offset", 32'(dut.offset), 32'd0);
    rst = 0;
    clear_model();
    @(negedge clk);
    chk("resume an", 32'(an), 32'hE);
    check_frame(0, 3, "after rst blank");
    wr(0, 5'h01, 0); wr(7, 5'h07, 0);
    msg_len = 0;
    @(negedge clk);
    check_frame(0, 0, "len zero");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
